// File: rtl/filter_decimator_pkg.sv
// Shared definitions for the filter chain: default sample width, sample type
// and the clog2-derived widths used by the decimator and its output FIFO.
// The optional block-average decimation is selected with the macro
// FILTER_DECIMATOR_AVG_EN (see filter_decimator.sv).
package filter_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_DECIM_FACTOR = 4;
    localparam int DEFAULT_FIFO_DEPTH   = 8;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

    // Counter/pointer width that never collapses to zero bits (a factor or
    // depth of 1 still needs a 1-bit register to be legal).
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int DEFAULT_PTR_W   = clog2_min1(DEFAULT_FIFO_DEPTH);
    localparam int DEFAULT_LEVEL_W = $clog2(DEFAULT_FIFO_DEPTH) + 1;
    localparam int DEFAULT_PHASE_W = clog2_min1(DEFAULT_DECIM_FACTOR);

endpackage : filter_pkg

// File: rtl/filter_decimator_if.sv
// Sample-in / decimated-out bundle of the filter decimator. The slave modport
// is the decimator's view; the master modport is the filter/consumer side.
interface filter_decimator_if
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [LEVEL_W-1:0]           fifo_level;
    logic                         overflow;
    logic                         clear_overflow;

    modport master (
        output data_in,
        output in_valid,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  fifo_level,
        input  overflow,
        output clear_overflow
    );

    modport slave (
        input  data_in,
        input  in_valid,
        output out_data,
        output out_valid,
        input  out_ready,
        output fifo_level,
        output overflow,
        input  clear_overflow
    );

endinterface : filter_decimator_if

// File: rtl/filter_decimator_sample_fifo.sv
// Generic first-word-fall-through FIFO for filter-chain stages.
// The head entry is held in a register so the read port shows 0 after reset
// and keeps the last head while empty. The caller must only assert i_push
// when (!o_full || i_pop) and only assert i_pop when !o_empty.
module sample_fifo
    import filter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W   = clog2_min1(DEPTH),
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   w_head_next;
    logic [PTR_W-1:0]   w_rd_ptr_inc;

    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    assign o_empty      = (r_level == '0);
    assign o_full       = (r_level == LEVEL_W'(DEPTH));
    assign o_level      = r_level;
    assign o_head       = r_head;

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Read/write pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= w_rd_ptr_inc;
        end
    end

    // Occupancy: unchanged on simultaneous push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else if (i_push && !i_pop) begin
            r_level <= r_level + 1'b1;
        end else if (i_pop && !i_push) begin
            r_level <= r_level - 1'b1;
        end
    end

    // Next head: the entry behind the popped one, or a sample written into
    // an empty (or emptying) FIFO bypasses storage so it shows next cycle.
    always_comb begin
        w_head_next = r_head;
        if (i_pop) begin
            if (r_level > LEVEL_W'(1)) begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (i_push) begin
                w_head_next = i_push_data;
            end
        end else if (o_empty && i_push) begin
            w_head_next = i_push_data;
        end
    end

    // Head register: 0 after reset, holds last value while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else begin
            r_head <= w_head_next;
        end
    end

endmodule : sample_fifo

// File: rtl/filter_decimator.sv
// Decimates the moving-average filter output by DECIM_FACTOR and buffers the
// decimated samples in a FWFT FIFO with a valid/ready output. The filter has
// no backpressure, so a sample arriving at a full FIFO is dropped and the
// sticky overflow flag is raised.
// Build option FILTER_DECIMATOR_AVG_EN: push the floor-average of each group
// of DECIM_FACTOR samples instead of the last sample of the group.
module filter_decimator
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DECIM_FACTOR = DEFAULT_DECIM_FACTOR,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    filter_decimator_if.slave dec
);

    localparam int PHASE_W = clog2_min1(DECIM_FACTOR);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM_FACTOR - 1);

    generate
        if (DECIM_FACTOR < 1) begin : g_bad_decim
            $error("filter_decimator: DECIM_FACTOR must be at least 1");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("filter_decimator: FIFO_DEPTH must be a power of 2 and at least 2");
        end
`ifdef FILTER_DECIMATOR_AVG_EN
        if ((DECIM_FACTOR & (DECIM_FACTOR - 1)) != 0) begin : g_bad_avg
            $error("filter_decimator: averaging needs a power-of-2 DECIM_FACTOR");
        end
`endif
    endgenerate

    logic [PHASE_W-1:0]    r_phase;
    logic                  r_overflow;
    logic                  w_event;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_dec_value;
    logic [DATA_WIDTH-1:0] w_head;
    logic [LEVEL_W-1:0]    w_level;

    assign w_event = dec.in_valid && (r_phase == PHASE_LAST);
    assign w_pop   = !w_empty && dec.out_ready;
    // A full FIFO still takes the sample when the consumer frees a slot
    // in the same cycle.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    // Phase within the current decimation group; only valid samples count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (dec.in_valid) begin
            r_phase <= w_event ? '0 : r_phase + 1'b1;
        end
    end

`ifdef FILTER_DECIMATOR_AVG_EN
    localparam int SHIFT = $clog2(DECIM_FACTOR);
    localparam int ACC_W = DATA_WIDTH + SHIFT;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_mean;

    // The event sample is folded in combinationally, so the group sum is
    // complete on the event cycle and the next group starts without a gap.
    assign w_sum       = r_acc + ACC_W'(dec.data_in);
    assign w_mean      = w_sum >>> SHIFT;
    assign w_dec_value = w_mean[DATA_WIDTH-1:0];

    // Group accumulator, cleared on each decimation event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (dec.in_valid) begin
            r_acc <= w_event ? '0 : w_sum;
        end
    end
`else
    // Keep-last: the filter already band-limits, so just subsample.
    assign w_dec_value = dec.data_in;
`endif

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (dec.clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_dec_value),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    assign dec.out_data   = w_head;
    assign dec.out_valid  = !w_empty;
    assign dec.fifo_level = w_level;
    assign dec.overflow   = r_overflow;

endmodule : filter_decimator

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator with a queue-based reference model of
// the decimate-and-buffer behaviour, checked every cycle, plus literal
// expectations for each scenario.
module tb_filter_decimator;
    import filter_pkg::*;

    localparam int DW    = 16;
    localparam int DECIM = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    filter_decimator_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dif ();

    filter_decimator #(
        .DATA_WIDTH   (DW),
        .DECIM_FACTOR (DECIM),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dec (dif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  mq[$];
    int  m_cnt       = 0;
    int  m_sum       = 0;
    int  m_last_head = 0;
    bit  m_ovf       = 0;
    bit  m_pop;
    bit  m_ev;
    int  m_val;

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_cnt       = 0;
            m_sum       = 0;
            m_last_head = 0;
            m_ovf       = 0;
        end else begin
            m_pop = (mq.size() != 0) && dif.out_ready;
            m_ev  = 0;
            m_val = 0;
            if (dif.in_valid) begin
                m_sum = m_sum + int'(dif.data_in);
                m_cnt = m_cnt + 1;
                if (m_cnt == DECIM) begin
                    m_ev = 1;
`ifdef FILTER_DECIMATOR_AVG_EN
                    m_val = floor_div(m_sum, DECIM);
`else
                    m_val = int'(dif.data_in);
`endif
                    m_cnt = 0;
                    m_sum = 0;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_ev && mq.size() >= DEPTH) m_ovf = 1;
            else begin
                if (m_ev) mq.push_back(m_val);
                if (dif.clear_overflow) m_ovf = 0;
            end
            if (mq.size() != 0) m_last_head = mq[0];
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid",  int'(dif.out_valid),  (mq.size() != 0) ? 1 : 0);
            check("fifo_level", int'(dif.fifo_level), mq.size());
            check("overflow",   int'(dif.overflow),   int'(m_ovf));
            check("out_data",   int'(dif.out_data),   (mq.size() != 0) ? mq[0] : m_last_head);
        end
    end

    // ---------------- stimulus ----------------
    int got[$];
    int max_lvl;

    // One clock: drive inputs, log a pop if one will happen, step the edge.
    task automatic cyc(input logic v, input int d, input logic rdy, input logic clr);
        dif.in_valid       = v;
        dif.data_in        = DW'(d);
        dif.out_ready      = rdy;
        dif.clear_overflow = clr;
        if (dif.out_valid && rdy) begin
            got.push_back(int'(dif.out_data));
            $display("OUT data=%0d level=%0d t=%0t", dif.out_data, dif.fifo_level, $time);
        end
        @(posedge clk);
        #1;
        if (int'(dif.fifo_level) > max_lvl) max_lvl = int'(dif.fifo_level);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, rdy, 1'b0);
    endtask

    task automatic group(input int d, input logic rdy);
        for (int i = 0; i < DECIM; i++) cyc(1'b1, d, rdy, 1'b0);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid",  int'(dif.out_valid),  0);
        check("rst_out_data",   int'(dif.out_data),   0);
        check("rst_fifo_level", int'(dif.fifo_level), 0);
        check("rst_overflow",   int'(dif.overflow),   0);
    endtask

    int exp_after_rst;

    initial begin
        dif.in_valid       = 1'b0;
        dif.data_in        = '0;
        dif.out_ready      = 1'b0;
        dif.clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        // Ramp 1..12, consumer always ready.
        got.delete();
        max_lvl = 0;
        for (int i = 1; i <= 12; i++) cyc(1'b1, i, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("ramp_count", got.size(), 3);
        if (got.size() == 3) begin
            check("ramp_out0", got[0], 4);
            check("ramp_out1", got[1], 8);
            check("ramp_out2", got[2], 12);
        end
        check("ramp_max_level", max_lvl, 1);

        // Gapped input: idle cycles must not advance the phase.
        got.delete();
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 10 * k, 1'b1, 1'b0);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        idle(3, 1'b1);
        check("gap_count", got.size(), 1);
        if (got.size() == 1) check("gap_out", got[0], 40);

        // Overflow: 9 events into a depth-8 FIFO with no consumer.
        for (int k = 1; k <= 9; k++) group(k, 1'b0);
        check("ovf_level", int'(dif.fifo_level), 8);
        check("ovf_flag",  int'(dif.overflow),   1);
        // Another drop with clear in the same cycle: set wins.
        for (int i = 0; i < DECIM - 1; i++) cyc(1'b1, 10, 1'b0, 1'b0);
        cyc(1'b1, 10, 1'b0, 1'b1);
        check("ovf_clear_vs_drop", int'(dif.overflow), 1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("ovf_clear_alone", int'(dif.overflow), 0);
        got.delete();
        idle(10, 1'b1);
        check("drain_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check("drain_out", got[i], i + 1);

        // Full FIFO with push and pop in the same cycle.
        for (int k = 21; k <= 28; k++) group(k, 1'b0);
        for (int i = 0; i < DECIM - 1; i++) cyc(1'b1, 29, 1'b0, 1'b0);
        got.delete();
        cyc(1'b1, 29, 1'b1, 1'b0);
        check("pp_level",    int'(dif.fifo_level), 8);
        check("pp_overflow", int'(dif.overflow),   0);
        idle(10, 1'b1);
        check("pp_count", got.size(), 9);
        if (got.size() == 9) begin
            check("pp_first",  got[0], 21);
            check("pp_second", got[1], 22);
            check("pp_last",   got[8], 29);
        end

        // Negative group: last sample is -3, floor(-9/4) is also -3.
        got.delete();
        cyc(1'b1, -1, 1'b1, 1'b0);
        cyc(1'b1, -2, 1'b1, 1'b0);
        cyc(1'b1, -3, 1'b1, 1'b0);
        cyc(1'b1, -3, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("neg_count", got.size(), 1);
        if (got.size() == 1) check("neg_out", got[0], -3);

        // Reset in the middle of a group.
        cyc(1'b1, 5, 1'b1, 1'b0);
        cyc(1'b1, 5, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        got.delete();
        cyc(1'b1, 7, 1'b1, 1'b0);
        cyc(1'b1, 8, 1'b1, 1'b0);
        cyc(1'b1, 9, 1'b1, 1'b0);
        cyc(1'b1, 10, 1'b1, 1'b0);
        idle(3, 1'b1);
`ifdef FILTER_DECIMATOR_AVG_EN
        exp_after_rst = 8;
`else
        exp_after_rst = 10;
`endif
        check("rst_group_count", got.size(), 1);
        if (got.size() == 1) check("rst_group_out", got[0], exp_after_rst);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_filter_decimator
